// File: rtl/branch_predict_flush_unit.sv
// rtl/branch_predict_flush_unit.sv - 2-bit saturating branch predictor table with EX resolution,
// flush generation and saturating branch/mispredict performance counters.
module branch_predict_flush_unit #(
  parameter int         PC_W        = 32,
  parameter int         IDX_W       = 6,
  parameter int         CNT_W       = 16,
  parameter logic [1:0] RESET_STATE = 2'b01
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PC_W-1:0]  if_pc,
  output logic             if_prediction,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic [1:0]       branch3,
  input  logic             prediction3,
  input  logic             aluZero,
  input  logic             exception,
  input  logic             stall,
  output logic             flush,
  output logic             mispredict,
  output logic             flush_q,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);
  localparam int DEPTH = 1 << IDX_W;

  logic [1:0]       pht_q [DEPTH];
  logic [1:0]       pht_d [DEPTH];
  logic [CNT_W-1:0] branch_count_q, branch_count_d;
  logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;
  logic             flush_d;
  logic             flush_r_q;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic             is_br, taken, train, count_en;
  logic [1:0]       ex_entry;

  // Only the word-index bits of the PCs select an entry.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0], ex_pc[PC_W-1:IDX_W+2], ex_pc[1:0]};

  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];

  // Read sees the registered table, so a same-cycle training write is not bypassed.
  assign if_prediction = pht_q[if_idx][1];

  assign is_br      = (branch3 == 2'b01) || (branch3 == 2'b11);
  assign taken      = (branch3 == 2'b01) ? aluZero : !aluZero;
  assign mispredict = is_br && (prediction3 != taken);
  assign flush      = mispredict || exception;

  assign count_en = !stall && !exception;
  assign train    = is_br && count_en;
  assign ex_entry = pht_q[ex_idx];

  always_comb begin
    pht_d = pht_q;
    if (train) begin
      if (taken && (ex_entry != 2'b11)) begin
        pht_d[ex_idx] = ex_entry + 2'd1;
      end else if (!taken && (ex_entry != 2'b00)) begin
        pht_d[ex_idx] = ex_entry - 2'd1;
      end
    end
  end

  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    flush_d            = flush;
    if (train && (branch_count_q != {CNT_W{1'b1}})) begin
      branch_count_d = branch_count_q + 1'b1;
    end
    if (count_en && mispredict && (mispredict_count_q != {CNT_W{1'b1}})) begin
      mispredict_count_d = mispredict_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pht_q[i] <= RESET_STATE;
      end
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
      flush_r_q          <= 1'b0;
    end else begin
      pht_q              <= pht_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
      flush_r_q          <= flush_d;
    end
  end

  assign flush_q          = flush_r_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_branch_predict_flush_unit.sv
// tb/tb_branch_predict_flush_unit.sv - randomized bench against a behavioural predictor model.
module tb_branch_predict_flush_unit;
  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc, ex_pc;
  logic [1:0]  branch3;
  logic        prediction3, aluZero, exception, stall;
  logic        if_prediction, flush, mispredict, flush_q;
  logic [15:0] branch_count, mispredict_count;
  logic        s_if_prediction, s_flush, s_mispredict, s_flush_q;
  logic [3:0]  s_branch_count, s_mispredict_count;

  branch_predict_flush_unit dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_prediction(if_prediction),
    .ex_pc(ex_pc), .branch3(branch3), .prediction3(prediction3), .aluZero(aluZero),
    .exception(exception), .stall(stall), .flush(flush), .mispredict(mispredict),
    .flush_q(flush_q), .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  branch_predict_flush_unit #(.CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_prediction(s_if_prediction),
    .ex_pc(ex_pc), .branch3(branch3), .prediction3(prediction3), .aluZero(aluZero),
    .exception(exception), .stall(stall), .flush(s_flush), .mispredict(s_mispredict),
    .flush_q(s_flush_q), .branch_count(s_branch_count), .mispredict_count(s_mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: predictor strength 0..3 per entry, unbounded event counts.
  int tbl [64];
  int br_total, mp_total;
  bit exp_fq;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) tbl[i] = 1;
    br_total = 0;
    mp_total = 0;
    exp_fq   = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_flush_q"}, flush_q, exp_fq);
    chk({tag, "_s_flush_q"}, s_flush_q, exp_fq);
    chk({tag, "_br_cnt"}, branch_count, sat(br_total, 65535));
    chk({tag, "_mp_cnt"}, mispredict_count, sat(mp_total, 65535));
    chk({tag, "_s_br_cnt"}, s_branch_count, sat(br_total, 15));
    chk({tag, "_s_mp_cnt"}, s_mispredict_count, sat(mp_total, 15));
  endtask

  // Called at a falling edge; applies one cycle of stimulus and checks both halves of it.
  task automatic cycle(input logic [31:0] ipc, input logic [31:0] epc, input logic [1:0] br,
                       input bit pred, input bit az, input bit exc, input bit stl, input string tag);
    bit is_br, tk, mp, fl;
    int e;
    if_pc = ipc; ex_pc = epc; branch3 = br; prediction3 = pred;
    aluZero = az; exception = exc; stall = stl;
    #1;
    is_br = (br == 2'd1) || (br == 2'd3);
    tk    = (br == 2'd1) ? az : !az;
    mp    = is_br && (pred != tk);
    fl    = mp || exc;
    chk({tag, "_if_pred"}, if_prediction, tbl[idx_of(ipc)] >= 2);
    chk({tag, "_s_if_pred"}, s_if_prediction, tbl[idx_of(ipc)] >= 2);
    chk({tag, "_flush"}, flush, fl);
    chk({tag, "_mispredict"}, mispredict, mp);
    @(posedge clk);
    e = idx_of(epc);
    if (is_br && !stl && !exc) begin
      tbl[e] = tk ? ((tbl[e] < 3) ? tbl[e] + 1 : 3) : ((tbl[e] > 0) ? tbl[e] - 1 : 0);
      br_total++;
    end
    if (mp && !stl && !exc) mp_total++;
    exp_fq = fl;
    @(negedge clk);
    check_state(tag);
  endtask

  task automatic idle();
    if_pc = 0; ex_pc = 0; branch3 = 0; prediction3 = 0;
    aluZero = 0; exception = 0; stall = 0;
  endtask

  initial begin
    logic [31:0] pcs [6];
    logic [31:0] a, b;
    pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h100;
    pcs[3] = 32'h104; pcs[4] = 32'h00400010; pcs[5] = 32'h00400014;

    idle();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_state("reset");
    for (int i = 0; i < 3; i++) begin
      if_pc = pcs[i * 2];
      #1 chk("reset_if_pred", if_prediction, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++)
      cycle(32'h00400010, 32'h00400010, 2'd1, 0, 1, 0, 0, "beq_sat");
    chk("beq_sat_entry", if_prediction, 1);
    chk("beq_sat_br3", branch_count, 3);
    chk("beq_sat_mp3", mispredict_count, 3);

    cycle(32'h200, 32'h200, 2'd3, 1, 0, 0, 0, "bne_ok");
    cycle(32'h200, 32'h200, 2'd1, 0, 0, 1, 0, "exc");
    cycle(32'h100, 32'h100, 2'd1, 0, 1, 0, 1, "stall");
    cycle(32'h100, 32'h100, 2'd1, 0, 1, 0, 0, "coll_n");
    chk("coll_n1_if_pred", if_prediction, 1);

    for (int i = 0; i < 20; i++)
      cycle(32'h0, (i % 2) ? 32'h100 : 32'h0, 2'd1, 0, 1, 0, 0, "sat");
    chk("sat_s_br", s_branch_count, 15);
    chk("sat_s_mp", s_mispredict_count, 15);
    cycle(32'h0, 32'h0, 2'd1, 0, 0, 0, 0, "sat_hold");

    for (int i = 0; i < 300; i++) begin
      a = ($urandom_range(0, 3) == 0) ? $urandom : pcs[$urandom_range(0, 5)];
      b = ($urandom_range(0, 3) == 0) ? $urandom : pcs[$urandom_range(0, 5)];
      cycle(a, b, 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
            $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, "rnd");
    end

    cycle(32'h00400010, 32'h00400010, 2'd1, 0, 1, 0, 0, "pre_rst");
    cycle(32'h00400010, 32'h00400010, 2'd0, 0, 0, 1, 0, "pre_rst_exc");
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_state("async_rst");
    chk("async_rst_if_pred", if_prediction, 0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    cycle(32'h00400010, 32'h00400010, 2'd3, 0, 0, 0, 0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_predict_flush_unit.md
Name: branch_predict_flush_unit

Overview:
- Parametrised successor to the pipeline flush logic.
- Holds a direct-mapped table of 2-bit saturating branch predictors, indexed by PC. IF stage gets a prediction from it.
- Resolves conditional branches in EX (beq/bne encoding), raises flush on mispredict or exception, and trains the predictor.
- Keeps saturating performance counters for branches and mispredicts.

Parameters:
- PC_W, 32, PC width in bits.
- IDX_W, 6, table index width; table depth is 2**IDX_W entries.
- CNT_W, 16, width of each performance counter.
- RESET_STATE, 2'b01, initial value of every predictor counter (weakly not-taken).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- if_pc  input  PC_W  fetch PC for lookup
- if_prediction  output  1  predicted taken for if_pc (combinational read)
- ex_pc  input  PC_W  PC of the branch in EX
- branch3  input  2  EX branch type: 01=beq (taken iff aluZero), 11=bne (taken iff !aluZero), 00/10=not a branch
- prediction3  input  1  prediction carried down the pipe with the EX instruction
- aluZero  input  1  EX ALU zero flag
- exception  input  1  exception raised this cycle
- stall  input  1  EX hold; suppresses training and counting
- flush  output  1  squash younger stages (combinational)
- mispredict  output  1  branch misprediction this cycle (combinational)
- flush_q  output  1  flush registered one cycle, for the stage-clear sequencer
- branch_count  output  CNT_W  resolved branches, saturating
- mispredict_count  output  CNT_W  mispredicts, saturating

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0:
  - every table entry is RESET_STATE;
  - flush_q, branch_count and mispredict_count are 0.
- Release of rst_n is taken synchronously at the next clk edge.
- Index: idx(pc) = pc[IDX_W+1:2]; the word-aligned low bits are ignored.
- Lookup: if_prediction = table[idx(if_pc)][1]. Pure combinational, zero latency.
- Resolution, combinational:
  - is_br = (branch3==01) | (branch3==11).
  - taken = (branch3==01) ? aluZero : !aluZero.
  - mispredict = is_br & (prediction3 != taken).
  - flush = mispredict | exception.
  - flush and mispredict are independent of stall; the pipeline is responsible for gating them.
- Training occurs on the clk edge when is_br & !stall & rst_n:
  - table[idx(ex_pc)] increments if taken, decrements otherwise;
  - it saturates at 11 and at 00.
- Training is suppressed when exception=1 in the same cycle; the faulting branch does not train.
- Same-index collision: when idx(if_pc)==idx(ex_pc) in the training cycle, if_prediction returns the pre-update value. The new value is visible from the next cycle. There is no bypass.
- Counters, both under !stall & !exception:
  - branch_count += 1 per trained branch;
  - mispredict_count += 1 when mispredict;
  - each holds at all-ones, with no wrap.
- flush_q <= flush every clk edge, regardless of stall.
- Non-branch types 00 and 10 never train, never count and never raise mispredict.
- Table storage is flops. Depth 2**IDX_W with IDX_W up to 10 is supported.

Test Plan:
- Reset state: hold rst_n=0, then release. Lookup any if_pc gives if_prediction=0. Counters read 0, flush_q=0. Assert rst_n low asynchronously mid-run and all state clears without a clock edge.
- beq training to saturation: ex_pc=0x00400010, branch3=01, aluZero=1, prediction3=0, three consecutive cycles.
  - First cycle: flush=1 and mispredict=1.
  - Entry goes 01→10→11→11.
  - if_pc=0x00400010 then predicts 1.
  - branch_count=3.
  - mispredict_count=3, since prediction3 is held at 0.
- bne correct prediction: branch3=11, aluZero=0, prediction3=1 → flush=0, mispredict=0, branch_count+1, mispredict_count unchanged.
- Exception priority: exception=1 with branch3=01, aluZero=0, prediction3=0 → flush=1, mispredict=0, no table or counter change; flush_q=1 on the next cycle.
- Stall and collision:
  - With stall=1 and a mispredicting branch: flush=1, but neither the table nor the counters change.
  - With stall=0, if_pc=ex_pc=0x100 and a training step 01→10 in cycle N: if_prediction=0 in cycle N and 1 in cycle N+1.
- Counter saturation: CNT_W=4 with 20 mispredicting branches → both counters stop at 15; aliasing ex_pc 0x000/0x100 with IDX_W=6 hits the same entry.
